// File: rtl/ex_stage.sv
// ex_stage -- execute stage of the RV64I pipeline.
//
// Resolves operand forwarding from EX/MEM and MEM/WB, computes the ALU
// result, resolves conditional branches and registers the EX/MEM outputs.
//
// Optional feature macro: EX_MUL_EN
//   defined   -> func7b0_d2 port present; an iterative shift-add multiplier
//                (IDLE/RUN/DONE) holds the front end through ex_busy.
//   undefined -> no multiplier; ex_busy tied to 0; MUL encodings run as ADD.
//
// Ports:
//   clk, rst            clock (rising edge), asynchronous active-low reset
//   pc_d2 .. reg_write_d2  ID/EX register contents of the instruction in EX
//   wb_rd, wb_reg_write, wb_data  MEM/WB forwarding source
//   *_d3                registered EX/MEM outputs
//   pc_src, branch_target  combinational branch resolution
//   ex_busy             hold request for IF/ID and ID/EX
module ex_stage #(
    parameter int XLEN = 64
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [XLEN-1:0] pc_d2,
    input  logic [XLEN-1:0] rs1_data_d2,
    input  logic [XLEN-1:0] rs2_data_d2,
    input  logic [4:0]      rs1_d2,
    input  logic [4:0]      rs2_d2,
    input  logic [4:0]      rd_d2,
    input  logic [XLEN-1:0] immediate_d2,
    input  logic [1:0]      alu_op_d2,
    input  logic            alu_src_d2,
    input  logic [2:0]      func3_d2,
    input  logic            func7b5_d2,
`ifdef EX_MUL_EN
    input  logic            func7b0_d2,
`endif
    input  logic            branch_d2,
    input  logic            mem_read_d2,
    input  logic            mem_write_d2,
    input  logic            mem_to_reg_d2,
    input  logic            reg_write_d2,
    input  logic [4:0]      wb_rd,
    input  logic            wb_reg_write,
    input  logic [XLEN-1:0] wb_data,
    output logic [XLEN-1:0] alu_result_d3,
    output logic [XLEN-1:0] store_data_d3,
    output logic [4:0]      rd_d3,
    output logic [2:0]      func3_d3,
    output logic            mem_read_d3,
    output logic            mem_write_d3,
    output logic            mem_to_reg_d3,
    output logic            reg_write_d3,
    output logic            pc_src,
    output logic [XLEN-1:0] branch_target,
    output logic            ex_busy
);

    logic [XLEN-1:0] fwd_a;
    logic [XLEN-1:0] fwd_b;
    logic [XLEN-1:0] op_b;
    logic [XLEN-1:0] alu_out;
    logic [XLEN-1:0] ex_result;
    logic            br_cond;
    logic            lt_s;
    logic            lt_u;
    logic            fwd_eq;

    // Forwarding: EX/MEM result wins over MEM/WB; x0 is never forwarded.
    always_comb begin
        fwd_a = rs1_data_d2;
        if (reg_write_d3 && rd_d3 != 5'd0 && rd_d3 == rs1_d2)
            fwd_a = alu_result_d3;
        else if (wb_reg_write && wb_rd != 5'd0 && wb_rd == rs1_d2)
            fwd_a = wb_data;
    end

    always_comb begin
        fwd_b = rs2_data_d2;
        if (reg_write_d3 && rd_d3 != 5'd0 && rd_d3 == rs2_d2)
            fwd_b = alu_result_d3;
        else if (wb_reg_write && wb_rd != 5'd0 && wb_rd == rs2_d2)
            fwd_b = wb_data;
    end

    assign op_b = alu_src_d2 ? immediate_d2 : fwd_b;

    // ALU
    always_comb begin
        alu_out = '0;
        case (alu_op_d2)
            2'b00: alu_out = fwd_a + op_b;
            2'b01: alu_out = fwd_a - op_b;
            2'b10: begin
                case (func3_d2)
                    3'b000: alu_out = (func7b5_d2 && !alu_src_d2) ? fwd_a - op_b
                                                                  : fwd_a + op_b;
                    3'b001: alu_out = fwd_a << op_b[5:0];
                    3'b010: alu_out = {{(XLEN-1){1'b0}}, $signed(fwd_a) < $signed(op_b)};
                    3'b011: alu_out = {{(XLEN-1){1'b0}}, fwd_a < op_b};
                    3'b100: alu_out = fwd_a ^ op_b;
                    3'b101: alu_out = func7b5_d2 ? XLEN'($signed(fwd_a) >>> op_b[5:0])
                                                 : fwd_a >> op_b[5:0];
                    3'b110: alu_out = fwd_a | op_b;
                    default: alu_out = fwd_a & op_b;
                endcase
            end
            default: alu_out = '0;
        endcase
    end

    // Branch resolution always compares the two forwarded registers.
    assign fwd_eq = (fwd_a == fwd_b);
    assign lt_s   = ($signed(fwd_a) < $signed(fwd_b));
    assign lt_u   = (fwd_a < fwd_b);

    always_comb begin
        br_cond = 1'b0;
        case (func3_d2)
            3'b000:  br_cond = fwd_eq;
            3'b001:  br_cond = !fwd_eq;
            3'b100:  br_cond = lt_s;
            3'b101:  br_cond = !lt_s;
            3'b110:  br_cond = lt_u;
            3'b111:  br_cond = !lt_u;
            default: br_cond = 1'b0;
        endcase
    end

    assign pc_src        = branch_d2 && !ex_busy && br_cond;
    assign branch_target = pc_d2 + immediate_d2;

`ifdef EX_MUL_EN
    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_DONE
    } mul_state_t;

    mul_state_t      mul_state;
    logic [XLEN-1:0] mcand;
    logic [XLEN-1:0] mplier;
    logic [XLEN-1:0] acc;
    logic [6:0]      step_cnt;
    logic            is_mul;

    assign is_mul = (alu_op_d2 == 2'b10) && !alu_src_d2 && func7b0_d2 &&
                    (func3_d2 == 3'b000);

    // Busy is gated by reset so a held MUL cannot request a stall in reset.
    assign ex_busy = rst && (((mul_state == S_IDLE) && is_mul) ||
                             (mul_state == S_RUN));

    // Operands are latched on entry so MEM/WB changes during RUN are ignored.
    // Only the low XLEN product bits are kept, so the multiplicand simply
    // shifts left and drops its overflow.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            mul_state <= S_IDLE;
            mcand     <= '0;
            mplier    <= '0;
            acc       <= '0;
            step_cnt  <= '0;
        end else begin
            case (mul_state)
                S_IDLE: begin
                    if (is_mul) begin
                        mcand     <= fwd_a;
                        mplier    <= fwd_b;
                        acc       <= '0;
                        step_cnt  <= '0;
                        mul_state <= S_RUN;
                    end
                end
                S_RUN: begin
                    if (mplier[0])
                        acc <= acc + mcand;
                    mcand    <= mcand << 1;
                    mplier   <= mplier >> 1;
                    step_cnt <= step_cnt + 7'd1;
                    if (step_cnt == 7'd63)
                        mul_state <= S_DONE;
                end
                default: begin
                    mul_state <= S_IDLE;
                end
            endcase
        end
    end

    assign ex_result = (mul_state == S_DONE) ? acc : alu_out;
`else
    assign ex_busy   = 1'b0;
    assign ex_result = alu_out;
`endif

    // EX/MEM register: a stall cycle inserts a bubble.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            alu_result_d3 <= '0;
            store_data_d3 <= '0;
            rd_d3         <= '0;
            func3_d3      <= '0;
            mem_read_d3   <= 1'b0;
            mem_write_d3  <= 1'b0;
            mem_to_reg_d3 <= 1'b0;
            reg_write_d3  <= 1'b0;
        end else if (ex_busy) begin
            alu_result_d3 <= '0;
            store_data_d3 <= '0;
            rd_d3         <= '0;
            func3_d3      <= '0;
            mem_read_d3   <= 1'b0;
            mem_write_d3  <= 1'b0;
            mem_to_reg_d3 <= 1'b0;
            reg_write_d3  <= 1'b0;
        end else begin
            alu_result_d3 <= ex_result;
            store_data_d3 <= fwd_b;
            rd_d3         <= rd_d2;
            func3_d3      <= func3_d2;
            mem_read_d3   <= mem_read_d2;
            mem_write_d3  <= mem_write_d2;
            mem_to_reg_d3 <= mem_to_reg_d2;
            reg_write_d3  <= reg_write_d2;
        end
    end

endmodule

// File: tb/tb_ex_stage.sv
module tb_ex_stage;

    logic        clk = 1'b0;
    logic        rst;
    logic [63:0] pc_d2, rs1_data_d2, rs2_data_d2, immediate_d2;
    logic [4:0]  rs1_d2, rs2_d2, rd_d2;
    logic [1:0]  alu_op_d2;
    logic        alu_src_d2, func7b5_d2;
    logic [2:0]  func3_d2;
`ifdef EX_MUL_EN
    logic        func7b0_d2;
`endif
    logic        branch_d2, mem_read_d2, mem_write_d2, mem_to_reg_d2, reg_write_d2;
    logic [4:0]  wb_rd;
    logic        wb_reg_write;
    logic [63:0] wb_data;
    logic [63:0] alu_result_d3, store_data_d3, branch_target;
    logic [4:0]  rd_d3;
    logic [2:0]  func3_d3;
    logic        mem_read_d3, mem_write_d3, mem_to_reg_d3, reg_write_d3;
    logic        pc_src, ex_busy;

    int n_pass = 0;
    int n_total = 0;

    ex_stage #(.XLEN(64)) dut (
        .clk(clk), .rst(rst),
        .pc_d2(pc_d2), .rs1_data_d2(rs1_data_d2), .rs2_data_d2(rs2_data_d2),
        .rs1_d2(rs1_d2), .rs2_d2(rs2_d2), .rd_d2(rd_d2),
        .immediate_d2(immediate_d2), .alu_op_d2(alu_op_d2), .alu_src_d2(alu_src_d2),
        .func3_d2(func3_d2), .func7b5_d2(func7b5_d2),
`ifdef EX_MUL_EN
        .func7b0_d2(func7b0_d2),
`endif
        .branch_d2(branch_d2), .mem_read_d2(mem_read_d2), .mem_write_d2(mem_write_d2),
        .mem_to_reg_d2(mem_to_reg_d2), .reg_write_d2(reg_write_d2),
        .wb_rd(wb_rd), .wb_reg_write(wb_reg_write), .wb_data(wb_data),
        .alu_result_d3(alu_result_d3), .store_data_d3(store_data_d3),
        .rd_d3(rd_d3), .func3_d3(func3_d3),
        .mem_read_d3(mem_read_d3), .mem_write_d3(mem_write_d3),
        .mem_to_reg_d3(mem_to_reg_d3), .reg_write_d3(reg_write_d3),
        .pc_src(pc_src), .branch_target(branch_target), .ex_busy(ex_busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    endtask

    // ---------------- behavioural model ----------------
    // Expected EX/MEM contents, plus an abstract multiply countdown:
    // 0 = no multiply, 65..2 = busy run cycles, 1 = result cycle.
    logic [63:0] e_res, e_sd;
    logic [4:0]  e_rd;
    logic [2:0]  e_f3;
    logic        e_mr, e_mw, e_m2r, e_rw;
    int          mul_left;
    logic [63:0] mul_a, mul_b;

    function automatic logic [63:0] m_fwd(input logic [4:0] idx, input logic [63:0] rf);
        if (e_rw && e_rd != 0 && e_rd == idx) return e_res;
        if (wb_reg_write && wb_rd != 0 && wb_rd == idx) return wb_data;
        return rf;
    endfunction

    function automatic logic [63:0] m_alu(input logic [63:0] a, input logic [63:0] b);
        int sh;
        sh = int'(b[5:0]);
        if (alu_op_d2 == 2'd0) return a + b;
        if (alu_op_d2 == 2'd1) return a - b;
        if (alu_op_d2 == 2'd3) return 64'd0;
        case (func3_d2)
            3'd0: return (func7b5_d2 && !alu_src_d2) ? a - b : a + b;
            3'd1: return a << sh;
            3'd2: return ($signed(a) < $signed(b)) ? 64'd1 : 64'd0;
            3'd3: return (a < b) ? 64'd1 : 64'd0;
            3'd4: return a ^ b;
            3'd5: return func7b5_d2 ? 64'($signed(a) >>> sh) : a >> sh;
            3'd6: return a | b;
            default: return a & b;
        endcase
    endfunction

    function automatic bit m_busy();
`ifdef EX_MUL_EN
        bit mul_enc;
        mul_enc = (alu_op_d2 == 2'd2) && !alu_src_d2 && func7b0_d2 && (func3_d2 == 3'd0);
        return rst && ((mul_left == 0 && mul_enc) || mul_left > 1);
`else
        return 1'b0;
`endif
    endfunction

    function automatic bit m_pc_src();
        logic [63:0] a, b;
        bit c;
        a = m_fwd(rs1_d2, rs1_data_d2);
        b = m_fwd(rs2_d2, rs2_data_d2);
        case (func3_d2)
            3'd0: c = (a == b);
            3'd1: c = (a != b);
            3'd4: c = $signed(a) < $signed(b);
            3'd5: c = $signed(a) >= $signed(b);
            3'd6: c = a < b;
            3'd7: c = a >= b;
            default: c = 1'b0;
        endcase
        return branch_d2 && !m_busy() && c;
    endfunction

    always @(posedge clk or negedge rst) begin
        logic [63:0] a, b;
        if (!rst) begin
            {e_res, e_sd, e_rd, e_f3, e_mr, e_mw, e_m2r, e_rw} <= '0;
            mul_left <= 0;
        end else begin
            a = m_fwd(rs1_d2, rs1_data_d2);
            b = m_fwd(rs2_d2, rs2_data_d2);
            if (mul_left == 1 || !m_busy()) begin
                e_res <= (mul_left == 1) ? mul_a * mul_b : m_alu(a, alu_src_d2 ? immediate_d2 : b);
                e_sd  <= b;
                e_rd  <= rd_d2;
                e_f3  <= func3_d2;
                e_mr  <= mem_read_d2;
                e_mw  <= mem_write_d2;
                e_m2r <= mem_to_reg_d2;
                e_rw  <= reg_write_d2;
                mul_left <= 0;
            end else begin
                {e_res, e_sd, e_rd, e_f3, e_mr, e_mw, e_m2r, e_rw} <= '0;
                if (mul_left == 0) begin
                    mul_a <= a;
                    mul_b <= b;
                    mul_left <= 65;
                end else begin
                    mul_left <= mul_left - 1;
                end
            end
        end
    end

    // Cycle-by-cycle comparison on the falling edge.
    always @(negedge clk) begin
        chk("alu_result_d3", alu_result_d3, e_res);
        chk("store_data_d3", store_data_d3, e_sd);
        chk("rd_d3", 64'(rd_d3), 64'(e_rd));
        chk("func3_d3", 64'(func3_d3), 64'(e_f3));
        chk("ctrl_d3", 64'({mem_read_d3, mem_write_d3, mem_to_reg_d3, reg_write_d3}),
            64'({e_mr, e_mw, e_m2r, e_rw}));
        chk("ex_busy", 64'(ex_busy), 64'(m_busy()));
        chk("pc_src", 64'(pc_src), 64'(m_pc_src()));
        chk("branch_target", branch_target, pc_d2 + immediate_d2);
    end

    // ---------------- stimulus ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic nop();
        pc_d2 = '0; rs1_data_d2 = '0; rs2_data_d2 = '0; immediate_d2 = '0;
        rs1_d2 = '0; rs2_d2 = '0; rd_d2 = '0;
        alu_op_d2 = '0; alu_src_d2 = 1'b0; func3_d2 = '0; func7b5_d2 = 1'b0;
`ifdef EX_MUL_EN
        func7b0_d2 = 1'b0;
`endif
        branch_d2 = 1'b0; mem_read_d2 = 1'b0; mem_write_d2 = 1'b0;
        mem_to_reg_d2 = 1'b0; reg_write_d2 = 1'b0;
        wb_rd = '0; wb_reg_write = 1'b0; wb_data = '0;
    endtask

    function automatic logic [63:0] rand_val();
        case ($urandom % 6)
            0: return 64'd0;
            1: return 64'd1;
            2: return '1;
            3: return -64'sd8;
            4: return 64'($urandom % 100);
            default: return {$urandom, $urandom};
        endcase
    endfunction

    task automatic rand_instr();
        pc_d2 = {$urandom, $urandom};
        rs1_d2 = 5'($urandom % 8); rs2_d2 = 5'($urandom % 8); rd_d2 = 5'($urandom % 8);
        rs1_data_d2 = rand_val(); rs2_data_d2 = rand_val();
        immediate_d2 = ($urandom % 2 == 0) ? 64'($urandom % 64) : rand_val();
        alu_op_d2 = 2'($urandom % 4); alu_src_d2 = 1'($urandom % 2);
        func3_d2 = 3'($urandom % 8); func7b5_d2 = 1'($urandom % 2);
        branch_d2 = 1'($urandom % 2); mem_read_d2 = 1'($urandom % 2);
        mem_write_d2 = 1'($urandom % 2); mem_to_reg_d2 = 1'($urandom % 2);
        reg_write_d2 = ($urandom % 4 != 0);
`ifdef EX_MUL_EN
        func7b0_d2 = ($urandom % 6 == 0);
        if ($urandom % 12 == 0) begin
            alu_op_d2 = 2'd2; alu_src_d2 = 1'b0; func3_d2 = 3'd0; func7b0_d2 = 1'b1;
        end
        if (func7b0_d2) func7b5_d2 = 1'b0;
`endif
    endtask

    bit hold;
    int busy_cycles;

    initial begin
        rst = 1'b1;
        nop();
        #1 rst = 1'b0;
        tick(); tick();
        #1;
        chk("reset_result", alu_result_d3, 64'd0);
        chk("reset_regwrite", 64'(reg_write_d3), 64'd0);
        chk("reset_busy", 64'(ex_busy), 64'd0);
        rst = 1'b1;
        tick();

        // EX/MEM forwarding chain
        rs1_d2 = 5'd1; rs1_data_d2 = 64'd3; rs2_d2 = 5'd2; rs2_data_d2 = 64'd4;
        rd_d2 = 5'd5; reg_write_d2 = 1'b1; alu_op_d2 = 2'd0;
        tick(); chk("add_x5", alu_result_d3, 64'd7);
        rs1_d2 = 5'd5; rs1_data_d2 = 64'd0; rs2_d2 = 5'd1; rs2_data_d2 = 64'd3;
        rd_d2 = 5'd6; alu_op_d2 = 2'd1;
        tick(); chk("sub_fwd", alu_result_d3, 64'd4);

        // Priority: EX/MEM (x5=7) over MEM/WB (x5=0x99)
        rs1_d2 = 5'd1; rs1_data_d2 = 64'd3; rs2_d2 = 5'd2; rs2_data_d2 = 64'd4;
        rd_d2 = 5'd5; alu_op_d2 = 2'd0;
        tick();
        rs1_d2 = 5'd5; rs1_data_d2 = 64'd0; rs2_d2 = 5'd0; rs2_data_d2 = 64'd0;
        wb_rd = 5'd5; wb_reg_write = 1'b1; wb_data = 64'h99; rd_d2 = 5'd8;
        tick(); chk("fwd_priority", alu_result_d3, 64'd7);

        // rd=0 is never forwarded
        wb_reg_write = 1'b0;
        rs1_d2 = 5'd1; rs1_data_d2 = 64'd3; rs2_d2 = 5'd2; rs2_data_d2 = 64'd4; rd_d2 = 5'd0;
        tick();
        rs1_d2 = 5'd0; rs1_data_d2 = 64'd0; rs2_d2 = 5'd0; rs2_data_d2 = 64'd0;
        wb_rd = 5'd0; wb_reg_write = 1'b1; wb_data = 64'h99; rd_d2 = 5'd9;
        tick(); chk("x0_no_fwd", alu_result_d3, 64'd0);

        // Branches
        nop();
        rs1_d2 = 5'd10; rs1_data_d2 = 64'd5; rs2_d2 = 5'd11; rs2_data_d2 = 64'd7;
        pc_d2 = 64'h100; immediate_d2 = 64'h20; branch_d2 = 1'b1; func3_d2 = 3'b001;
        #1;
        chk("bne_taken", 64'(pc_src), 64'd1);
        chk("bne_target", branch_target, 64'h120);
        tick();
        func3_d2 = 3'b101; rs1_data_d2 = '1; rs2_data_d2 = 64'd1;
        #1 chk("bge_not_taken", 64'(pc_src), 64'd0);
        tick();
        func3_d2 = 3'b111;
        #1 chk("bgeu_taken", 64'(pc_src), 64'd1);
        tick();

        // Shifts and compares
        nop();
        rs1_d2 = 5'd10; rs1_data_d2 = -64'sd8; rs2_d2 = 5'd11; rs2_data_d2 = 64'd1;
        alu_op_d2 = 2'd2; func3_d2 = 3'b101; func7b5_d2 = 1'b1; alu_src_d2 = 1'b1;
        immediate_d2 = 64'd1; rd_d2 = 5'd3; reg_write_d2 = 1'b1;
        tick(); chk("sra", alu_result_d3, 64'hFFFF_FFFF_FFFF_FFFC);
        func7b5_d2 = 1'b0; immediate_d2 = 64'd60;
        tick(); chk("srl", alu_result_d3, 64'hF);
        alu_src_d2 = 1'b0; func3_d2 = 3'b010; rs1_data_d2 = '1;
        tick(); chk("slt", alu_result_d3, 64'd1);
        func3_d2 = 3'b011;
        tick(); chk("sltu", alu_result_d3, 64'd0);

`ifdef EX_MUL_EN
        nop(); tick();
        rs1_d2 = 5'd12; rs1_data_d2 = '1; rs2_d2 = 5'd13; rs2_data_d2 = 64'd3;
        alu_op_d2 = 2'd2; func3_d2 = 3'd0; func7b0_d2 = 1'b1; rd_d2 = 5'd7; reg_write_d2 = 1'b1;
        #1;
        busy_cycles = 0;
        while (ex_busy && busy_cycles < 200) begin
            busy_cycles++;
            tick(); #1;
        end
        chk("mul_busy_cycles", 64'(busy_cycles), 64'd65);
        chk("mul_bubble", 64'(reg_write_d3), 64'd0);
        tick();
        chk("mul_result", alu_result_d3, 64'hFFFF_FFFF_FFFF_FFFD);
        chk("mul_rd", 64'(rd_d3), 64'd7);

        // Reset in RUN cycle 30 aborts the multiply
        nop(); tick();
        rs1_d2 = 5'd12; rs1_data_d2 = '1; rs2_d2 = 5'd13; rs2_data_d2 = 64'd3;
        alu_op_d2 = 2'd2; func3_d2 = 3'd0; func7b0_d2 = 1'b1; rd_d2 = 5'd7; reg_write_d2 = 1'b1;
        repeat (30) tick();
        rst = 1'b0;
        #1;
        chk("abort_busy", 64'(ex_busy), 64'd0);
        chk("abort_result", alu_result_d3, 64'd0);
        chk("abort_regwrite", 64'(reg_write_d3), 64'd0);
        nop(); tick();
        rst = 1'b1;
        tick();
        chk("abort_no_output", alu_result_d3, 64'd0);
`else
        nop();
        rs1_d2 = 5'd12; rs1_data_d2 = 64'd5; rs2_d2 = 5'd13; rs2_data_d2 = 64'd6;
        alu_op_d2 = 2'd2; func3_d2 = 3'd0; rd_d2 = 5'd7; reg_write_d2 = 1'b1;
        #1 chk("mul_enc_no_busy", 64'(ex_busy), 64'd0);
        tick(); chk("mul_enc_as_add", alu_result_d3, 64'd11);
`endif

        // Randomized phase; ID/EX is held while the model says busy.
        for (int i = 0; i < 800; i++) begin
            hold = m_busy();
            tick();
            if (!hold) rand_instr();
            wb_rd = 5'($urandom % 8);
            wb_reg_write = 1'($urandom % 2);
            wb_data = rand_val();
        end
        tick();

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
